// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, state encodings, ALUOp/select encodings and the DECODE dispatch.
package mips_mc_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03, FUNCT_JR = 6'h08;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    RWB, IEXEC, IWB, BRANCH, JUMP, JAL_ST, JR_ST
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b100, ALU_SUB = 3'b001, ALU_OR = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110, ALU_LUI = 3'b000, ALU_RTYPE = 3'b111;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] MR_ALUOUT = 2'd0, MR_MDR = 2'd1, MR_PC = 2'd2;
  localparam logic [1:0] SB_B = 2'd0, SB_4 = 2'd1, SB_IMM = 2'd2, SB_IMMSH = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_A = 2'd3;
  // FETCH as the successor of DECODE means the instruction is unsupported.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn, input logic jumps);
    case (op)
      OP_R: return fn == FUNCT_JR ? (jumps ? JR_ST : FETCH) : EXECUTE;
      OP_LW, OP_SW: return MEMADR;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return IEXEC;
      OP_J: return jumps ? JUMP : FETCH;
      OP_JAL: return jumps ? JAL_ST : FETCH;
      default: return FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: IR/flag inputs and datapath control outputs of the multicycle controller.
interface mips_multicycle_control_if #(parameter int ALUOP_W = 3);
  logic [5:0] Opcode, Funct;
  logic Zero, MemReady;
  logic IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite, IllegalOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0] State;
  modport master(input Opcode, Funct, Zero, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite, IllegalOp,
    output RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, State);
  modport slave(output Opcode, Funct, Zero, MemReady,
    input IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite, IllegalOp,
    input RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, State);
endinterface

// File: rtl/mips_mc_out_decode.sv
// mips_mc_out_decode: combinational map from controller state and IR fields to datapath controls.
module mips_mc_out_decode import mips_mc_pkg::*; #(
  parameter int ALUOP_W = 3,
  parameter bit SUPPORT_JUMPS = 1
) (
  input logic reset,
  input state_t state,
  mips_multicycle_control_if.master bus
);
  always_comb begin
    bus.IorD = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.PCWrite = 1'b0;
    bus.IllegalOp = 1'b0;
    bus.RegDst = RD_RT;
    bus.MemtoReg = MR_ALUOUT;
    bus.ALUSrcB = SB_B;
    bus.PCSource = PC_ALU;
    bus.ALUOp = ALUOP_W'(ALU_LUI);
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SB_4;
          bus.ALUOp = ALUOP_W'(ALU_ADD);
          bus.IRWrite = bus.MemReady;
          bus.PCWrite = bus.MemReady;
        end
        DECODE: begin
          bus.ALUSrcB = SB_IMMSH;
          bus.ALUOp = ALUOP_W'(ALU_ADD);
          bus.IllegalOp = decode_next(bus.Opcode, bus.Funct, SUPPORT_JUMPS) == FETCH;
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SB_IMM;
          bus.ALUOp = ALUOP_W'(ALU_ADD);
        end
        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = MR_MDR;
        end
        MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD = 1'b1;
        end
        EXECUTE: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp = ALUOP_W'(ALU_RTYPE);
        end
        RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst = RD_RD;
        end
        IEXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SB_IMM;
          bus.ALUOp = ALUOP_W'(bus.Opcode == OP_ORI ? ALU_OR : bus.Opcode == OP_ANDI ? ALU_AND :
                               bus.Opcode == OP_LUI ? ALU_LUI : ALU_ADD);
        end
        IWB: bus.RegWrite = 1'b1;
        BRANCH: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp = ALUOP_W'(ALU_SUB);
          bus.PCSource = PC_ALUOUT;
          bus.PCWrite = bus.Opcode == OP_BNE ? ~bus.Zero : bus.Zero;
        end
        JUMP: begin
          bus.PCSource = PC_JUMP;
          bus.PCWrite = 1'b1;
        end
        JAL_ST: begin
          bus.PCSource = PC_JUMP;
          bus.PCWrite = 1'b1;
          bus.RegWrite = 1'b1;
          bus.RegDst = RD_RA;
          bus.MemtoReg = MR_PC;
        end
        JR_ST: begin
          bus.PCSource = PC_A;
          bus.PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/write-back for the multicycle MIPS datapath.
module mips_multicycle_control import mips_mc_pkg::*; #(
  parameter int ALUOP_W = 3,
  parameter bit SUPPORT_JUMPS = 1,
  parameter int RA_REG = 31
) (
  input logic clk,
  input logic reset,
  mips_multicycle_control_if.master bus
);
  state_t state, state_n;
  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_check
    $error("RA_REG must name one of the 32 registers");
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_n;
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH: state_n = bus.MemReady ? DECODE : FETCH;
      DECODE: state_n = decode_next(bus.Opcode, bus.Funct, SUPPORT_JUMPS);
      MEMADR: state_n = bus.Opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD: state_n = bus.MemReady ? MEMWB : MEMRD;
      MEMWR: state_n = bus.MemReady ? FETCH : MEMWR;
      EXECUTE: state_n = RWB;
      IEXEC: state_n = IWB;
      default: state_n = FETCH;
    endcase
  end
  assign bus.State = state;
  mips_mc_out_decode #(.ALUOP_W(ALUOP_W), .SUPPORT_JUMPS(SUPPORT_JUMPS)) u_out (
    .reset(reset),
    .state(state),
    .bus(bus)
  );
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: per-cycle scoreboard of expected state and controls for each instruction class.
module tb_mips_multicycle_control;
  typedef struct packed {
    logic iord, mrd, mwr, irw;
    logic [1:0] rd, mtr;
    logic rw, sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic pcw, ill;
  } o_t;
  typedef struct packed {bit sel; logic [3:0] st; o_t o;} ent_t;
  typedef struct packed {logic [3:0] st; logic [5:0] op, fn; logic z, mr, ill;} stp_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  ent_t sb[$];
  mips_multicycle_control_if #(.ALUOP_W(3)) ba ();
  mips_multicycle_control_if #(.ALUOP_W(3)) bb ();
  mips_multicycle_control #(.ALUOP_W(3), .SUPPORT_JUMPS(1), .RA_REG(31)) dut_a (.clk(clk), .reset(reset), .bus(ba));
  mips_multicycle_control #(.ALUOP_W(3), .SUPPORT_JUMPS(0), .RA_REG(31)) dut_b (.clk(clk), .reset(reset), .bus(bb));
  always #5 clk = ~clk;
  function automatic o_t ex(input logic [3:0] st, input logic [5:0] op, input logic z, mr, ill);
    o_t o = '0;
    case (st)
      4'd0: begin o.mrd = 1; o.sb = 1; o.alu = 3'b100; o.irw = mr; o.pcw = mr; end
      4'd1: begin o.sb = 3; o.alu = 3'b100; o.ill = ill; end
      4'd2: begin o.sa = 1; o.sb = 2; o.alu = 3'b100; end
      4'd3: begin o.mrd = 1; o.iord = 1; end
      4'd4: begin o.rw = 1; o.mtr = 1; end
      4'd5: begin o.mwr = 1; o.iord = 1; end
      4'd6: begin o.sa = 1; o.alu = 3'b111; end
      4'd7: begin o.rw = 1; o.rd = 1; end
      4'd8: begin
        o.sa = 1; o.sb = 2;
        o.alu = op == 6'h0d ? 3'b101 : op == 6'h0c ? 3'b110 : op == 6'h0f ? 3'b000 : 3'b100;
      end
      4'd9: o.rw = 1;
      4'd10: begin o.sa = 1; o.alu = 3'b001; o.pcs = 1; o.pcw = op == 6'h05 ? ~z : z; end
      4'd11: begin o.pcs = 2; o.pcw = 1; end
      4'd12: begin o.pcs = 2; o.pcw = 1; o.rw = 1; o.rd = 2; o.mtr = 2; end
      4'd13: begin o.pcs = 3; o.pcw = 1; end
      default: ;
    endcase
    return o;
  endfunction
  function automatic logic [22:0] obs(input bit sel);
    return sel ? {bb.State, bb.IorD, bb.MemRead, bb.MemWrite, bb.IRWrite, bb.RegDst, bb.MemtoReg,
                  bb.RegWrite, bb.ALUSrcA, bb.ALUSrcB, bb.ALUOp, bb.PCSource, bb.PCWrite, bb.IllegalOp}
               : {ba.State, ba.IorD, ba.MemRead, ba.MemWrite, ba.IRWrite, ba.RegDst, ba.MemtoReg,
                  ba.RegWrite, ba.ALUSrcA, ba.ALUSrcB, ba.ALUOp, ba.PCSource, ba.PCWrite, ba.IllegalOp};
  endfunction
  function automatic stp_t mk(input int st, op, fn, z, mr, ill);
    return '{4'(st), 6'(op), 6'(fn), 1'(z), 1'(mr), 1'(ill)};
  endfunction
  task automatic push(input bit sel, input stp_t x);
    if (sel) begin bb.Opcode = x.op; bb.Funct = x.fn; bb.Zero = x.z; bb.MemReady = x.mr; end
    else begin ba.Opcode = x.op; ba.Funct = x.fn; ba.Zero = x.z; ba.MemReady = x.mr; end
    sb.push_back('{sel, x.st, ex(x.st, x.op, x.z, x.mr, x.ill)});
  endtask
  task automatic test_reset();
    ent_t e;
    @(negedge clk);
    checks++;
    if (obs(0) !== 23'd0) begin failures++; $display("FAIL reset_a got=%h want=0", obs(0)); end
    checks++;
    if (obs(1) !== 23'd0) begin failures++; $display("FAIL reset_b got=%h want=0", obs(1)); end
    @(posedge clk); #1 reset = 1'b0;
    push(0, mk(0, 0, 0, 0, 0, 0));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL reset_release got=%h want=%h", obs(e.sel), {e.st, e.o}); end
    @(posedge clk); #1;
  endtask
  task automatic test_rtype();
    ent_t e;
    stp_t s[$] = '{mk(0, 0, 'h20, 0, 1, 0), mk(1, 0, 'h20, 0, 1, 0), mk(6, 0, 'h20, 0, 1, 0),
                   mk(7, 0, 'h20, 0, 1, 0), mk(0, 0, 'h20, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL rtype[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h23, 0, 0, 1, 0), mk(1, 'h23, 0, 0, 1, 0), mk(2, 'h23, 0, 0, 1, 0),
                   mk(3, 'h23, 0, 0, 0, 0), mk(3, 'h23, 0, 0, 0, 0), mk(3, 'h23, 0, 0, 0, 0),
                   mk(3, 'h23, 0, 0, 1, 0), mk(4, 'h23, 0, 0, 0, 0), mk(0, 'h23, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL load[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_store();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h2b, 0, 0, 1, 0), mk(1, 'h2b, 0, 0, 1, 0), mk(2, 'h2b, 0, 0, 1, 0),
                   mk(5, 'h2b, 0, 0, 0, 0), mk(5, 'h2b, 0, 0, 1, 0), mk(0, 'h2b, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL store[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h04, 0, 0, 1, 0), mk(1, 'h04, 0, 0, 1, 0), mk(10, 'h04, 0, 1, 1, 0),
                   mk(0, 'h05, 0, 0, 1, 0), mk(1, 'h05, 0, 0, 1, 0), mk(10, 'h05, 0, 1, 1, 0),
                   mk(0, 'h05, 0, 0, 1, 0), mk(1, 'h05, 0, 0, 1, 0), mk(10, 'h05, 0, 0, 1, 0),
                   mk(0, 'h04, 0, 0, 1, 0), mk(1, 'h04, 0, 0, 1, 0), mk(10, 'h04, 0, 0, 1, 0),
                   mk(0, 'h04, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL branch[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_itype();
    ent_t e;
    stp_t s[$];
    int ops[4] = '{'h08, 'h0d, 'h0c, 'h0f};
    foreach (ops[k]) begin
      s.push_back(mk(0, ops[k], 0, 0, 1, 0));
      s.push_back(mk(1, ops[k], 0, 0, 1, 0));
      s.push_back(mk(8, ops[k], 0, 0, 1, 0));
      s.push_back(mk(9, ops[k], 0, 0, 1, 0));
    end
    s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL itype[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_jumps();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h02, 0, 0, 1, 0), mk(1, 'h02, 0, 0, 1, 0), mk(11, 'h02, 0, 0, 1, 0),
                   mk(0, 'h03, 0, 0, 1, 0), mk(1, 'h03, 0, 0, 1, 0), mk(12, 'h03, 0, 0, 1, 0),
                   mk(0, 0, 'h08, 0, 1, 0), mk(1, 0, 'h08, 0, 1, 0), mk(13, 0, 'h08, 0, 1, 0),
                   mk(0, 0, 'h08, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL jumps[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_illegal();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h3f, 0, 0, 1, 0), mk(1, 'h3f, 0, 0, 1, 1), mk(0, 'h3f, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL illegal[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_no_jumps();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h02, 0, 0, 1, 0), mk(1, 'h02, 0, 0, 1, 1), mk(0, 0, 'h08, 0, 1, 0),
                   mk(1, 0, 'h08, 0, 1, 1), mk(0, 'h03, 0, 0, 1, 0), mk(1, 'h03, 0, 0, 1, 1),
                   mk(0, 0, 'h20, 0, 1, 0), mk(1, 0, 'h20, 0, 1, 0), mk(6, 0, 'h20, 0, 1, 0),
                   mk(7, 0, 'h20, 0, 1, 0), mk(0, 0, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(1, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL no_jumps[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h0d, 0, 0, 1, 0), mk(1, 'h0d, 0, 0, 1, 0), mk(8, 'h0d, 0, 0, 1, 0),
                   mk(9, 'h0d, 0, 0, 1, 0), mk(0, 'h23, 0, 0, 1, 0), mk(1, 'h23, 0, 0, 1, 0),
                   mk(2, 'h23, 0, 0, 1, 0), mk(3, 'h23, 0, 0, 1, 0), mk(4, 'h23, 0, 0, 1, 0),
                   mk(0, 'h23, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_midaccess();
    ent_t e;
    stp_t s[$] = '{mk(0, 'h23, 0, 0, 1, 0), mk(1, 'h23, 0, 0, 1, 0), mk(2, 'h23, 0, 0, 1, 0),
                   mk(3, 'h23, 0, 0, 0, 0)};
    foreach (s[i]) begin
      push(0, s[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL mid_reset[%0d] got=%h want=%h", i, obs(e.sel), {e.st, e.o}); end
      if (i < s.size() - 1) begin @(posedge clk); #1; end
    end
    #2 reset = 1'b1;
    #1 checks++;
    if (obs(0) !== 23'd0) begin failures++; $display("FAIL mid_reset_async got=%h want=0", obs(0)); end
    @(posedge clk); #1 reset = 1'b0;
    push(0, mk(0, 'h23, 0, 0, 0, 0));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (obs(e.sel) !== {e.st, e.o}) begin failures++; $display("FAIL mid_reset_release got=%h want=%h", obs(e.sel), {e.st, e.o}); end
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    ba.Opcode = 6'h00; ba.Funct = 6'h00; ba.Zero = 1'b0; ba.MemReady = 1'b0;
    bb.Opcode = 6'h00; bb.Funct = 6'h00; bb.Zero = 1'b0; bb.MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_itype();
    test_jumps();
    test_illegal();
    test_no_jumps();
    test_back_to_back();
    test_reset_midaccess();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS control unit. A Moore FSM sequences every instruction through fetch, decode, execute, memory and write-back cycles.
- Drives the shared-memory multicycle datapath.
- Adds J, JAL and JR support, a memory-ready handshake, an illegal-opcode flag, and a parametrised ALUOp width.
- Sits between the instruction register/ALU Zero flag and all datapath mux selects and write enables.

Parameters:
- ALUOP_W, 3, ALUOp width. Encodings are zero-extended: ADD=100, SUB=001, OR=101, AND=110, LUI=000, RTYPE=111.
- SUPPORT_JUMPS, 1, when 0, J/JAL/JR are treated as illegal.
- RA_REG, 31, informational only; RegDst=2 selects this register in the datapath.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0]; used only for JR detection (Opcode=0, Funct=6'h08).
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory handshake; memory access states hold until it is 1.
- IorD  out  1  0=PC address, 1=ALUOut address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  0=rt, 1=rd, 2=RA_REG.
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC (return address).
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  0=B, 1=const 4, 2=SignImm, 3=SignImm<<2.
- ALUOp  out  ALUOP_W  ALU operation.
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=A register.
- PCWrite  out  1  effective PC enable; branch condition already folded in.
- IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- State  out  4  current state, for debug and bench.

Behaviour:
- Reset: state=FETCH. All write enables and strobes are 0 while reset is high. All selects are 0 and ALUOp=0 while reset is high. Reset is honoured in any state, including mid-memory-access.
- Outputs depend only on state, except PCWrite in BRANCH (uses Zero), and IRWrite/PCWrite in FETCH (use MemReady).
- Outputs not listed for a state are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (precomputes branch target).
  - Next state: LW/SW -> MEMADR; R-type (not JR) -> EXECUTE; JR -> JR_ST; BEQ/BNE -> BRANCH; ADDI/ORI/ANDI/LUI -> IEXEC; J -> JUMP; JAL -> JAL_ST.
  - Any other opcode -> FETCH with IllegalOp=1.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH. MemWrite stays asserted while waiting.
- EXECUTE: ALUSrcA=1, ALUSrcB=0, ALUOp=RTYPE. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2, ALUOp per opcode (ADDI=ADD, ORI=OR, ANDI=AND, LUI=LUI). Goes to IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1.
  - PCWrite=Zero for BEQ; PCWrite=~Zero for BNE.
  - Goes to FETCH.
- JUMP: PCSource=2, PCWrite=1. Goes to FETCH.
- JAL_ST: PCSource=2, PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=2. Goes to FETCH. The PC register still holds PC+4 during this cycle, so the link value is correct.
- JR_ST: PCSource=3, PCWrite=1. Goes to FETCH.
- Opcode may change while in FETCH. Opcode and Funct are sampled only in DECODE, MEMADR, IEXEC and BRANCH, where the IR is stable.
- Unreachable state encodings -> FETCH.
- CPI: R-type/I-type 4, LW 5, SW 4, branch 3, J/JAL/JR 3, plus memory wait cycles.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode localparams (R=0, ADDI=08, ORI=0d, ANDI=0c, LUI=0f, LW=23, SW=2b, BEQ=04, BNE=05, J=02, JAL=03) and FUNCT_JR=08;
  - 4-bit state encodings FETCH=0 … JR_ST=13 (14 states);
  - ALUOp encodings;
  - select encodings for RegDst, MemtoReg, ALUSrcB and PCSource.
- One natural sub-module: mips_mc_out_decode, a combinational map from (State, Opcode, Zero, MemReady) to outputs. The top module keeps the state register and next-state logic.

Test Plan:
- Reset asserted in MEMRD with MemReady=0 -> State=0 asynchronously, MemRead=0 and all enables 0. After release, FETCH with MemRead=1.
- ADD (Opcode=0, Funct=20), MemReady=1 -> states 0,1,EXECUTE,RWB. RegWrite=1 only in RWB, with RegDst=1. Back to FETCH on cycle 5.
- LW with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles with IorD=1 and MemRead=1. MEMWB asserts RegWrite=1 and MemtoReg=1. Total 8 cycles.
- BEQ with Zero=1 -> PCWrite=1, PCSource=1 in BRANCH. BNE with Zero=1 -> PCWrite=0.
- JAL -> JAL_ST asserts PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. JR (Opcode=0, Funct=08) -> JR_ST with PCSource=3.
- Opcode=6'h3f -> IllegalOp=1 for one cycle in DECODE, next state FETCH. With SUPPORT_JUMPS=0, J -> IllegalOp=1.
